// File: rtl/data_ram_responder.sv
// rtl/data_ram_responder.sv - word-wide data RAM responder with programmable wait states and byte-lane stores
module data_ram_responder #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int WAIT_STATES   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        request_write,
  input  logic [31:0] request_address,
  input  logic [3:0]  request_select,
  input  logic [31:0] request_data,
  output logic        response_valid,
  output logic [31:0] response_data,
  output logic        response_error
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] LAST_COUNT = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {
    S_RESET_EXIT,
    S_IDLE,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t                   r_state;
  logic [CW-1:0]            r_count;
  logic                     r_write;
  logic [ADDRESS_WIDTH-1:0] r_index;
  logic [3:0]               r_select;
  logic [31:0]              r_data;
  logic                     r_error;
  logic                     r_ready;
  logic                     r_resp_valid;
  logic [31:0]              r_resp_data;
  logic                     r_resp_error;
  logic [31:0]              r_mem [0:DEPTH-1];

  logic                     w_req_error;
  logic [ADDRESS_WIDTH-1:0] w_rd_index;
  logic                     w_rd_error;
  logic                     w_rd_write;
  logic [31:0]              w_resp_data;
  logic                     w_commit;
  logic                     w_unused_addr_lsbs;

  // Byte offset within the word is carried by the select lanes, not the address.
  assign w_unused_addr_lsbs = ^request_address[1:0];

  assign w_req_error = (request_address[31:ADDRESS_WIDTH+2] != '0) || (request_select == 4'b0000);

  // With zero wait states the response is loaded on the accepting edge, so the
  // live request fields must be used instead of the not-yet-latched copies.
  assign w_rd_index  = (r_state == S_IDLE) ? request_address[ADDRESS_WIDTH+1:2] : r_index;
  assign w_rd_error  = (r_state == S_IDLE) ? w_req_error : r_error;
  assign w_rd_write  = (r_state == S_IDLE) ? request_write : r_write;
  assign w_resp_data = (w_rd_error || w_rd_write) ? 32'h0 : r_mem[w_rd_index];

  // Stores land on the edge that ends RESPOND; a reset before then drops them.
  assign w_commit = (r_state == S_RESPOND) && r_write && !r_error;

  assign request_ready  = r_ready;
  assign response_valid = r_resp_valid;
  assign response_data  = r_resp_data;
  assign response_error = r_resp_error;

  // Request sequencing: accept in IDLE, count wait states, pulse the response for one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_RESET_EXIT;
      r_count      <= '0;
      r_write      <= 1'b0;
      r_index      <= '0;
      r_select     <= 4'b0000;
      r_data       <= 32'h0;
      r_error      <= 1'b0;
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'h0;
      r_resp_error <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'h0;
      r_resp_error <= 1'b0;
      case (r_state)
        S_RESET_EXIT: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        S_IDLE: begin
          if (request_valid) begin
            r_write  <= request_write;
            r_index  <= request_address[ADDRESS_WIDTH+1:2];
            r_select <= request_select;
            r_data   <= request_data;
            r_error  <= w_req_error;
            r_count  <= '0;
            r_ready  <= 1'b0;
            if (WAIT_STATES > 0) begin
              r_state <= S_WAIT;
            end else begin
              r_state      <= S_RESPOND;
              r_resp_valid <= 1'b1;
              r_resp_data  <= w_resp_data;
              r_resp_error <= w_rd_error;
            end
          end
        end
        S_WAIT: begin
          if (r_count == LAST_COUNT) begin
            r_state      <= S_RESPOND;
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_resp_data;
            r_resp_error <= w_rd_error;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        S_RESPOND: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Storage: per-lane write enables; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_select[i]) begin
          r_mem[r_index][8*i +: 8] <= r_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// tb/tb_data_ram_responder.sv - self-checking bench for data_ram_responder at 1, 0 and 15 wait states
module tb_data_ram_responder;

  localparam int AW = 10;
  localparam int NEVER = 32'h7fffffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_write = '0;
  logic [2:0]  rdy;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_err;
  logic [31:0] req_addr [3];
  logic [31:0] req_data [3];
  logic [3:0]  req_sel  [3];
  logic [31:0] rsp_data [3];

  data_ram_responder #(.ADDRESS_WIDTH(AW), .WAIT_STATES(1)) u_ws1 (
    .clock(clk), .reset(rst_n),
    .request_valid(req_valid[0]), .request_ready(rdy[0]), .request_write(req_write[0]),
    .request_address(req_addr[0]), .request_select(req_sel[0]), .request_data(req_data[0]),
    .response_valid(rsp_valid[0]), .response_data(rsp_data[0]), .response_error(rsp_err[0]));

  data_ram_responder #(.ADDRESS_WIDTH(AW), .WAIT_STATES(0)) u_ws0 (
    .clock(clk), .reset(rst_n),
    .request_valid(req_valid[1]), .request_ready(rdy[1]), .request_write(req_write[1]),
    .request_address(req_addr[1]), .request_select(req_sel[1]), .request_data(req_data[1]),
    .response_valid(rsp_valid[1]), .response_data(rsp_data[1]), .response_error(rsp_err[1]));

  data_ram_responder #(.ADDRESS_WIDTH(AW), .WAIT_STATES(15)) u_ws15 (
    .clock(clk), .reset(rst_n),
    .request_valid(req_valid[2]), .request_ready(rdy[2]), .request_write(req_write[2]),
    .request_address(req_addr[2]), .request_select(req_sel[2]), .request_data(req_data[2]),
    .response_valid(rsp_valid[2]), .response_data(rsp_data[2]), .response_error(rsp_err[2]));

  function automatic int ws_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 15;
    endcase
  endfunction

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  bit          in_reset = 1'b1;
  bit          started = 1'b0;
  int          ready_from [3];
  bit          pend [3];
  int          resp_cyc [3];
  logic [31:0] exp_d [3];
  bit          exp_e [3];
  bit          st_do [3];
  int          st_idx [3];
  logic [3:0]  st_sel [3];
  logic [31:0] st_data [3];
  int          acc_cnt [3];
  int          last_acc_cyc [3];
  logic [31:0] mem_m [3][1024];

  // Observed DUT activity
  int          rsp_cnt [3];
  int          dut_acc [3];
  int          last_rsp_cyc [3];
  logic [31:0] last_rsp_d [3];
  logic        last_rsp_e [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      ready_from[k] = NEVER; pend[k] = 0; acc_cnt[k] = 0; rsp_cnt[k] = 0; dut_acc[k] = 0;
      req_addr[k] = 32'h0; req_data[k] = 32'h0; req_sel[k] = 4'h0;
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ws=%0d cyc=%0d actual=%h expected=%h", nm, ws_of(k), cyc, act, exp);
    end
  endtask

  // Model: one outstanding request; response WS+1 cycles after acceptance, ready again one cycle later.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        pend[k] = 0;
        ready_from[k] = NEVER;
      end else if (in_reset) begin
        ready_from[k] = cyc + 1;
      end else if (pend[k]) begin
        if (cyc == resp_cyc[k]) begin
          if (st_do[k])
            for (int b = 0; b < 4; b++)
              if (st_sel[k][b]) mem_m[k][st_idx[k]][8*b +: 8] = st_data[k][8*b +: 8];
          pend[k] = 0;
        end
      end else if (cyc >= ready_from[k] && req_valid[k]) begin
        automatic int idx = int'(req_addr[k][AW+1:2]);
        automatic bit bad = ((req_addr[k] >> (AW + 2)) != 0) || (req_sel[k] == 4'b0000);
        exp_e[k]   = bad;
        exp_d[k]   = (bad || req_write[k]) ? 32'h0 : mem_m[k][idx];
        st_do[k]   = req_write[k] && !bad;
        st_idx[k]  = idx;
        st_sel[k]  = req_sel[k];
        st_data[k] = req_data[k];
        pend[k]    = 1;
        resp_cyc[k]   = cyc + 1 + ws_of(k);
        ready_from[k] = cyc + 2 + ws_of(k);
        last_acc_cyc[k] = cyc;
        acc_cnt[k]++;
      end
    end
    if (!rst_n) begin
      in_reset = 1;
      started = 1;
    end else begin
      in_reset = 0;
    end
    cyc = cyc + 1;
  end

  // Compare every output of every instance once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        automatic bit live = rst_n && !in_reset;
        automatic bit ev = live && pend[k] && (cyc == resp_cyc[k]);
        chk("request_ready", k, rdy[k], live && (cyc >= ready_from[k]));
        chk("response_valid", k, rsp_valid[k], ev);
        chk("response_data", k, rsp_data[k], ev ? exp_d[k] : 32'h0);
        chk("response_error", k, rsp_err[k], ev ? exp_e[k] : 1'b0);
        if (rsp_valid[k] === 1'b1) begin
          rsp_cnt[k]++;
          last_rsp_cyc[k] = cyc;
          last_rsp_d[k] = rsp_data[k];
          last_rsp_e[k] = rsp_err[k];
        end
        if (rdy[k] === 1'b1 && req_valid[k]) dut_acc[k]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_req(input int k, input bit wr, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d);
    int a0, r0, n;
    a0 = acc_cnt[k];
    r0 = rsp_cnt[k];
    req_write[k] = wr; req_addr[k] = a; req_sel[k] = s; req_data[k] = d; req_valid[k] = 1'b1;
    n = 0;
    while (acc_cnt[k] == a0 && n < 60) begin tick(); n++; end
    if (acc_cnt[k] == a0) begin
      checks++; errors++;
      $display("FAIL accept_timeout ws=%0d actual=none required=acceptance", ws_of(k));
    end
    req_valid[k] = 1'b0;
    req_write[k] = 1'($urandom); req_addr[k] = $urandom; req_sel[k] = 4'($urandom); req_data[k] = $urandom;
    n = 0;
    while (rsp_cnt[k] == r0 && n < 60) begin tick(); n++; end
    if (rsp_cnt[k] == r0) begin
      checks++; errors++;
      $display("FAIL response_timeout ws=%0d actual=none required=response", ws_of(k));
    end
  endtask

  task automatic expect_load(input int k, input logic [31:0] a, input logic [31:0] d, input bit e,
                             input string nm);
    do_req(k, 1'b0, a, 4'hF, 32'h0);
    chk(nm, k, last_rsp_d[k], d);
    chk({nm, "_err"}, k, last_rsp_e[k], e);
  endtask

  task automatic hold_test(input int k);
    int a0, d0, w;
    w = ws_of(k) + 2;
    a0 = acc_cnt[k];
    d0 = dut_acc[k];
    req_write[k] = 1'b0; req_addr[k] = 32'h8; req_sel[k] = 4'hF; req_valid[k] = 1'b1;
    repeat (3 * w) tick();
    req_valid[k] = 1'b0;
    repeat (w + 2) tick();
    chk("hold_dut_accepts", k, dut_acc[k] - d0, 3);
    chk("hold_model_accepts", k, acc_cnt[k] - a0, 3);
  endtask

  task automatic random_test(input int k, input int nops);
    for (int i = 0; i < 16; i++) do_req(k, 1'b1, 32'(i * 4), 4'hF, $urandom);
    for (int i = 0; i < nops; i++) begin
      automatic int kind = $urandom_range(0, 9);
      automatic logic [31:0] a = {26'h0, 4'($urandom), 2'($urandom)};
      if (kind >= 8) a = a | (32'h1 << $urandom_range(AW + 2, 31));
      if (kind < 4) do_req(k, 1'b0, a, 4'($urandom), 32'h0);
      else          do_req(k, 1'b1, a, 4'($urandom), $urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_first_cycle", 0, {29'h0, rdy}, 32'h0);
    @(negedge clk);
    chk("ready_second_cycle", 0, {29'h0, rdy}, 32'h7);
    tick();

    // One wait state: full-word store and reload, byte and halfword lanes, swl/swr lanes
    do_req(0, 1'b1, 32'h8, 4'b1111, 32'h44556677);
    chk("store_latency", 0, last_rsp_cyc[0] - last_acc_cyc[0], 2);
    expect_load(0, 32'h8, 32'h44556677, 1'b0, "lw_full");
    chk("load_latency", 0, last_rsp_cyc[0] - last_acc_cyc[0], 2);
    do_req(0, 1'b1, 32'h8, 4'b1000, 32'hBB000000);
    do_req(0, 1'b1, 32'hA, 4'b0011, 32'h00008899);
    expect_load(0, 32'h8, 32'hBB558899, 1'b0, "lw_sb_sh");
    do_req(0, 1'b1, 32'h8, 4'b0111, 32'h00AABBCC);
    expect_load(0, 32'h8, 32'hBBAABBCC, 1'b0, "lw_swl");
    do_req(0, 1'b1, 32'h8, 4'b1000, 32'hFF000000);
    expect_load(0, 32'h8, 32'hFFAABBCC, 1'b0, "lw_swr");

    // Errors: out-of-range address and empty select
    expect_load(0, 32'h00001000, 32'h0, 1'b1, "lw_out_of_range");
    do_req(0, 1'b1, 32'h8, 4'b0000, 32'h11111111);
    chk("store_sel0_err", 0, last_rsp_e[0], 1'b1);
    expect_load(0, 32'h8, 32'hFFAABBCC, 1'b0, "lw_after_sel0");

    // Reset during WAIT drops the store and its response
    do_req(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
    begin
      int a0, r0, n;
      a0 = acc_cnt[0];
      r0 = rsp_cnt[0];
      req_write[0] = 1'b1; req_addr[0] = 32'h0; req_sel[0] = 4'hF; req_data[0] = 32'h12345678;
      req_valid[0] = 1'b1;
      n = 0;
      while (acc_cnt[0] == a0 && n < 20) begin tick(); n++; end
      rst_n = 1'b0;
      req_valid[0] = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("reset_accepted_first", 0, acc_cnt[0] - a0, 1);
      chk("no_response_after_reset", 0, rsp_cnt[0] - r0, 0);
    end
    expect_load(0, 32'h0, 32'hCAFEF00D, 1'b0, "lw_after_reset");
    hold_test(0);

    // Zero wait states
    do_req(1, 1'b1, 32'h8, 4'hF, 32'h44556677);
    chk("store_latency", 1, last_rsp_cyc[1] - last_acc_cyc[1], 1);
    do_req(1, 1'b1, 32'hB, 4'b0001, 32'h000000EE);
    expect_load(1, 32'h8, 32'h445566EE, 1'b0, "lw_ws0");
    hold_test(1);

    // Fifteen wait states
    do_req(2, 1'b1, 32'h8, 4'hF, 32'h44556677);
    chk("store_latency", 2, last_rsp_cyc[2] - last_acc_cyc[2], 16);
    do_req(2, 1'b1, 32'h9, 4'b0100, 32'h00120000);
    expect_load(2, 32'h8, 32'h44126677, 1'b0, "lw_ws15");
    hold_test(2);

    random_test(0, 40);
    random_test(1, 40);
    random_test(2, 25);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
